// File: rtl/axis_mem_reader_if.sv
// AXI-Stream beat bundle produced by axis_mem_reader and consumed downstream.
interface axis_mem_reader_if #(
  parameter int DATA_WIDTH = 128
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_mem_reader.sv
// Memory-to-stream reader: turns a (base, byte count) command into fixed-latency
// SRAM reads and an AXI-Stream burst with tkeep/tlast.
module axis_mem_reader #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 32,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = MEM_LATENCY + 2
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic                                    s_cmd_valid,
  output logic                                    s_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]                   s_cmd_addr,
  input  logic [LEN_WIDTH-1:0]                    s_cmd_bytes,
  output logic                                    mem_rd_en,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]                   mem_rd_data,
  axis_mem_reader_if.master                       m_axis,
  output logic                                    busy,
  output logic                                    done
);

  localparam int BPB    = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BPB);
  localparam int WA_W   = ADDR_WIDTH - OFF_W;
  localparam int BEAT_W = LEN_WIDTH - OFF_W + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = CNT_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [WA_W-1:0]       waddr_q, rd_addr_q;
  logic [BEAT_W-1:0]     beats_q, cmd_beats;
  logic [BEAT_W-1:0]     reads_left_q, reads_left_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [OFF_W-1:0]      rem_q;
  logic [CNT_W-1:0]      inflight_q, inflight_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MEM_LATENCY-1:0] vld_q, vld_d;
  logic                  rd_en_q;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [OCC_W-1:0]      occ;
  logic                  cmd_fire, issue, push, pop, last_beat, not_empty;
  logic                  unused_addr_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [BPB-1:0] keep_mask(input logic [OFF_W-1:0] r);
    logic [BPB:0] m;
    m = ((BPB+1)'(1) << r) - (BPB+1)'(1);
    return (r == '0) ? {BPB{1'b1}} : m[BPB-1:0];
  endfunction

  assign unused_addr_lsb = ^s_cmd_addr[OFF_W-1:0];
  assign cmd_beats = BEAT_W'(s_cmd_bytes[LEN_WIDTH-1:OFF_W]) + BEAT_W'(|s_cmd_bytes[OFF_W-1:0]);

  assign s_cmd_ready = (state_q == S_IDLE);
  assign cmd_fire    = s_cmd_valid && s_cmd_ready;
  assign not_empty   = (cnt_q != '0);
  assign pop         = not_empty && m_axis.tready;
  assign push        = vld_q[MEM_LATENCY-1];
  assign last_beat   = (beat_cnt_q == beats_q - BEAT_W'(1));

  // A beat leaving this cycle frees its slot, so credit is checked after the pop.
  assign occ   = OCC_W'(inflight_q) + OCC_W'(cnt_q) - OCC_W'(pop);
  assign issue = (state_q == S_RUN) && (reads_left_q != '0) && (occ < OCC_W'(FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    reads_left_d = reads_left_q;
    beat_cnt_d   = beat_cnt_q;
    inflight_d   = inflight_q + CNT_W'(issue) - CNT_W'(push);
    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    vld_d        = MEM_LATENCY'({vld_q, rd_en_q});
    if (cmd_fire) begin
      reads_left_d = cmd_beats;
      beat_cnt_d   = '0;
    end
    if (issue) reads_left_d = reads_left_q - BEAT_W'(1);
    if (pop)   beat_cnt_d   = beat_cnt_q + BEAT_W'(1);
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = (cmd_beats == '0) ? S_DONE : S_RUN;
      S_RUN:   if (pop && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      reads_left_q <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      vld_q        <= '0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      reads_left_q <= reads_left_d;
      beat_cnt_q   <= beat_cnt_d;
      inflight_q   <= inflight_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      vld_q        <= vld_d;
      rd_en_q      <= issue;
    end
  end

  // Address, length and buffer storage carry no reset; control above qualifies them.
  always_ff @(posedge aclk) begin
    if (cmd_fire) begin
      waddr_q <= s_cmd_addr[ADDR_WIDTH-1:OFF_W];
      beats_q <= cmd_beats;
      rem_q   <= s_cmd_bytes[OFF_W-1:0];
    end else if (issue) begin
      rd_addr_q <= waddr_q;
      waddr_q   <= waddr_q + WA_W'(1);
    end
    if (push) fifo_q[wr_ptr_q] <= mem_rd_data;
  end

  assign mem_rd_en     = rd_en_q;
  assign mem_rd_addr   = rd_addr_q;
  assign m_axis.tvalid = not_empty;
  assign m_axis.tdata  = fifo_q[rd_ptr_q];
  assign m_axis.tlast  = not_empty && last_beat;
  assign m_axis.tkeep  = !not_empty ? '0 : (last_beat ? keep_mask(rem_q) : {BPB{1'b1}});
  assign busy          = cmd_fire || (state_q == S_RUN);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_axis_mem_reader.sv
// Directed bench for axis_mem_reader with a latency-matched memory model and
// a beat scoreboard filled when each command is driven.
module tb_axis_mem_reader;
  localparam int DW = 128;
  localparam int ML = 2;
  localparam int FD = ML + 2;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         s_cmd_valid = 1'b0;
  logic         s_cmd_ready;
  logic [31:0]  s_cmd_addr = '0;
  logic [31:0]  s_cmd_bytes = '0;
  logic         mem_rd_en;
  logic [27:0]  mem_rd_addr;
  logic [127:0] mem_rd_data;
  logic         busy, done;
  logic         tready_r = 1'b1;
  logic         rdy_rand = 1'b0;

  axis_mem_reader_if #(.DATA_WIDTH(DW)) axis ();
  assign axis.tready = tready_r;

  axis_mem_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .LEN_WIDTH(32), .MEM_LATENCY(ML)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_addr(s_cmd_addr), .s_cmd_bytes(s_cmd_bytes),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .m_axis(axis), .busy(busy), .done(done)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [127:0] memword(input logic [27:0] wa);
    return {~{4'h0, wa}, {4'h5, wa} ^ 32'h1234_5678, {4'hA, wa}, 32'(wa) * 32'd2654435761};
  endfunction

  // SRAM model: address sampled with the strobe, word presented MEM_LATENCY edges later.
  logic [27:0] pa [ML];
  always @(posedge aclk) begin
    pa[0] <= mem_rd_addr;
    for (int i = 1; i < ML; i++) pa[i] <= pa[i-1];
  end
  assign mem_rd_data = memword(pa[ML-1]);

  always @(posedge aclk) begin
    #1;
    tready_r = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int total = 0;
  int bad = 0;
  beat_t sb[$];
  logic [27:0] rd_addrs[$];
  int tlast_q[$];
  int beat_cnt, first_vld, first_beat, last_beat_c, done_cnt, done_cyc, busy_cnt, hs_edge;
  logic [15:0] last_keep;
  logic stall_prev = 1'b0;
  beat_t held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      total++;
      assert (int'(dut.inflight_q) + int'(dut.cnt_q) <= FD) else begin
        bad++;
        $error("FAIL occupancy observed=%0d expected<=%0d", int'(dut.inflight_q) + int'(dut.cnt_q), FD);
      end
      if (stall_prev) begin
        total++;
        assert ({axis.tdata, axis.tkeep, axis.tlast} === held) else begin
          bad++;
          $error("FAIL stall_hold observed=%0h expected=%0h", {axis.tdata, axis.tkeep, axis.tlast}, held);
        end
      end
      if (mem_rd_en) rd_addrs.push_back(mem_rd_addr);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (axis.tvalid && first_vld < 0) first_vld = cyc;
      if (axis.tvalid && axis.tready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_beat observed=%0h expected=none", axis.tdata);
        end
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          total++;
          assert ({axis.tdata, axis.tkeep, axis.tlast} === e) else begin
            bad++;
            $error("FAIL beat%0d observed=%0h/%0h/%0b expected=%0h/%0h/%0b", beat_cnt,
                   axis.tdata, axis.tkeep, axis.tlast, e.d, e.k, e.l);
          end
        end
        if (beat_cnt == 0) first_beat = cyc;
        last_beat_c = cyc;
        beat_cnt++;
        if (axis.tlast) begin tlast_q.push_back(cyc); last_keep = axis.tkeep; end
      end
      stall_prev = axis.tvalid && !axis.tready;
      held = {axis.tdata, axis.tkeep, axis.tlast};
    end
  end

  task automatic clear_stats();
    beat_cnt = 0; first_vld = -1; first_beat = -1; last_beat_c = -1;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; last_keep = '0;
    rd_addrs.delete(); tlast_q.delete();
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] bytes);
    int nb, rem;
    logic ok;
    beat_t b;
    nb = int'((64'(bytes) + 15) / 16);
    rem = int'(bytes % 16);
    for (int i = 0; i < nb; i++) begin
      b.d = memword(addr[31:4] + 28'(i));
      b.k = (i == nb - 1 && rem != 0) ? ((16'h1 << rem) - 16'h1) : 16'hFFFF;
      b.l = (i == nb - 1);
      sb.push_back(b);
    end
    s_cmd_valid = 1'b1; s_cmd_addr = addr; s_cmd_bytes = bytes;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge aclk);
      ok = s_cmd_ready;
      @(posedge aclk); #1;
    end
    hs_edge = cyc;
    s_cmd_valid = 1'b0;
    chk("cmd_accept", ok, 1'b1);
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) begin
      @(posedge aclk); #1;
    end
    chk("done_seen", done_cnt >= n, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    @(negedge aclk);
    chk({tag, "_ready"}, s_cmd_ready, 1'b1);
    chk({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, "_tvalid"}, axis.tvalid, 1'b0);
    chk({tag, "_tlast"}, axis.tlast, 1'b0);
    chk({tag, "_tkeep"}, axis.tkeep, 16'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    clear_stats();
    check_reset("rst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk); #1;

    // 64 bytes at 0x100: four full beats, no bubbles
    clear_stats();
    send_cmd(32'h100, 32'd64);
    wait_done(1, 200);
    chk("t1_beats", beat_cnt, 4);
    chk("t1_latency", first_vld - hs_edge, 4);
    chk("t1_nreads", rd_addrs.size(), 4);
    for (int i = 0; i < 4 && i < rd_addrs.size(); i++) chk("t1_rdaddr", rd_addrs[i], 28'h10 + 28'(i));
    chk("t1_nobubble", last_beat_c - first_beat, 3);
    chk("t1_done_lat", done_cyc - last_beat_c, 1);
    chk("t1_last_keep", last_keep, 16'hFFFF);

    // 20 bytes, low address bits ignored: partial last beat
    clear_stats();
    send_cmd(32'h2004, 32'd20);
    wait_done(1, 200);
    chk("t2_beats", beat_cnt, 2);
    chk("t2_last_keep", last_keep, 16'h000F);
    chk("t2_rdaddr0", rd_addrs.size() > 0 ? rd_addrs[0] : 28'hFFFFFFF, 28'h200);

    // zero-length command
    clear_stats();
    send_cmd(32'h300, 32'd0);
    repeat (6) @(posedge aclk); #1;
    chk("t3_nreads", rd_addrs.size(), 0);
    chk("t3_beats", beat_cnt, 0);
    chk("t3_tvalid", first_vld, -1);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_cyc", done_cyc, hs_edge);
    chk("t3_busy_cnt", busy_cnt, 1);

    // 4000 bytes under random backpressure
    clear_stats();
    rdy_rand = 1'b1;
    send_cmd(32'h8000, 32'd4000);
    wait_done(1, 5000);
    chk("t4_beats", beat_cnt, 250);
    chk("t4_sb_empty", sb.size(), 0);

    // reset at beat 100 of a 250-beat transfer
    clear_stats();
    send_cmd(32'h4000, 32'd4000);
    for (int i = 0; i < 3000 && beat_cnt < 100; i++) @(negedge aclk);
    chk("t5_reached100", beat_cnt >= 100, 1'b1);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    sb.delete();
    check_reset("midrst");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    rdy_rand = 1'b0;
    clear_stats();
    repeat (10) @(posedge aclk); #1;
    chk("t5_no_stale", beat_cnt, 0);
    chk("t5_no_done", done_cnt, 0);
    send_cmd(32'h9000, 32'd32);
    wait_done(1, 200);
    chk("t5_beats", beat_cnt, 2);
    chk("t5_rdaddr0", rd_addrs.size() > 0 ? rd_addrs[0] : 28'hFFFFFFF, 28'h900);

    // back-to-back commands
    clear_stats();
    send_cmd(32'hA000, 32'd48);
    send_cmd(32'hB010, 32'd17);
    wait_done(2, 200);
    chk("t6_beats", beat_cnt, 5);
    chk("t6_done_cnt", done_cnt, 2);
    chk("t6_ntlast", tlast_q.size(), 2);
    chk("t6_gap", hs_edge - ((tlast_q.size() > 0 ? tlast_q[0] : -100) + 1), 2);
    chk("t6_last_keep", last_keep, 16'h0001);
    chk("t6_sb_empty", sb.size(), 0);

    repeat (2) @(posedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_mem_reader.md
Name: axis_mem_reader

Overview:
RTL memory-to-stream DMA reader. It accepts a (base address, byte count) command, reads the region word by word from an on-chip SRAM read port with fixed latency, and emits it as an AXI-Stream master with tkeep/tlast. It feeds the dnn_engine pixel and weight slave ports in hardware, doing the same job as the bench's M2S push of (base, bpt).

Parameters:
DATA_WIDTH, 128, stream and memory word width in bits; multiple of 8
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 32, byte count width
MEM_LATENCY, 2, cycles from mem_rd_en sampled to mem_rd_data valid; at least 1
FIFO_DEPTH, MEM_LATENCY+2, output buffer entries; at least MEM_LATENCY+1

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_cmd_valid  in  1  command valid
s_cmd_ready  out  1  command accept; high only in IDLE
s_cmd_addr  in  ADDR_WIDTH  byte base address; low log2(DATA_WIDTH/8) bits ignored, treated as 0
s_cmd_bytes  in  LEN_WIDTH  bytes to transfer (bpt)
mem_rd_en  out  1  read strobe
mem_rd_addr  out  ADDR_WIDTH-log2(DATA_WIDTH/8)  word address
mem_rd_data  in  DATA_WIDTH  read data, MEM_LATENCY cycles after mem_rd_en
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tkeep  out  DATA_WIDTH/8  byte enables
m_axis_tlast  out  1  final beat of command
busy  out  1  high from command accept until the done pulse
done  out  1  one-cycle pulse after the final beat handshake

Behaviour:
- Reset values: s_cmd_ready=1, mem_rd_en=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, busy=0, done=0. The read-latency valid pipeline, the FIFO and all counters clear. In-flight read data is discarded.
- Reset asserted mid-transfer aborts the transfer immediately. After release the block is in IDLE and emits no stale beats.
- BPB = DATA_WIDTH/8.
- beats = ceil(bytes/BPB).
- rem = bytes mod BPB.
- FSM states:
  - IDLE: s_cmd_ready=1. On s_cmd_valid&&s_cmd_ready, latch the word address, beats and rem. Go to RUN if beats>0. If bytes==0, go to DONE.
  - RUN: issue reads and drain the FIFO. When the last beat handshakes (tvalid&&tready&&tlast), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Read issue:
  - Condition: mem_rd_en=1 when reads_left>0 && (inflight+fifo_count) < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows under any tready pattern.
  - mem_rd_addr starts at the base word address and increments by 1 per issued read.
  - The first read is issued the cycle after the command handshake.
- Return path:
  - A MEM_LATENCY-deep valid shift register tags each return.
  - Returned data is written into the FIFO on the edge it is valid.
  - inflight counts issued reads not yet returned; the counter handles simultaneous issue and return in the same cycle.
- Output:
  - m_axis_tvalid = FIFO not empty; tdata is the FIFO head.
  - A pop occurs on tvalid&&tready.
  - A FIFO push and pop in the same cycle keep fifo_count unchanged.
  - tdata, tkeep and tlast hold stable while tvalid&&!tready (AXI rule).
- Beat counter: counts popped beats.
  - tlast=1 only on beat index beats-1.
  - tkeep is all ones on non-final beats.
  - On the final beat, tkeep = (1<<rem)-1 if rem!=0, else all ones.
- Latency and throughput:
  - First tvalid appears MEM_LATENCY+2 cycles after the command handshake edge.
  - With tready held high, the stream sustains 1 beat/cycle and has no bubbles.
- Wrap-around: the word address wraps modulo 2^(ADDR_WIDTH-log2 BPB) silently.
- Back-to-back commands: the next command is accepted in IDLE, the cycle after done. Minimum gap is 2 cycles between the tlast handshake and the next s_cmd_ready handshake.
- s_cmd_valid while busy is ignored; s_cmd_ready=0, no latch.

Test Plan:
- DATA_WIDTH=128, addr=0x100, bytes=64, tready=1 -> mem_rd_addr 0x10..0x13; 4 beats with tkeep=0xFFFF; tlast on beat 4; first tvalid 4 cycles after cmd; done 1 cycle after beat 4.
- bytes=20 -> 2 beats; beat 1 tkeep=0xFFFF; beat 2 tkeep=0x000F with tlast=1.
- bytes=0 -> no mem_rd_en, no tvalid; done pulses 1 cycle after the cmd handshake; busy high for that 1 cycle.
- bytes=4000, tready random 50% -> 250 beats, data equal to the memory model in order. Assert (inflight+fifo_count)<=FIFO_DEPTH every cycle, and assert tdata/tkeep/tlast stable while stalled.
- Reset pulse at beat 100 of a 250-beat transfer -> outputs take reset values. Next command bytes=32 yields exactly 2 fresh beats from the new address, with no stale data.
- Two commands back-to-back (bytes=48, then bytes=17 at a new address), tready=1 -> 3+2 beats. Second command accepted 2 cycles after the first tlast. Final tkeep=0x0001; two done pulses.
